priority_arbiter: RTL and testbench

PRIORITY_ARBITER -- requirements
Module: priority_arbiter

---
 rtl/priority_arbiter.sv | 104 ++++++++++
 tb/tb_priority_arbiter.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/priority_arbiter.sv
// priority_arbiter: requester 0 has fixed top priority; the others share round-robin, hold-limited grants
module priority_arbiter #(
  parameter int N_REQ      = 3,
  parameter int HOLD_MAX   = 2,
  parameter int CNT_W      = 8,
  parameter bit PREEMPT_EN = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ-1:0]         done,
  output logic [N_REQ-1:0]         grant,
  output logic [$clog2(N_REQ)-1:0] accmodule,
  output logic [1:0]               mstate,
  output logic                     timeout,
  output logic [CNT_W-1:0]         nb_interrupts
);
  localparam int IW = $clog2(N_REQ);
  typedef enum logic [1:0] {IDLE, HI_ACTIVE, LO_ACTIVE, PREEMPT} state_t;
  state_t           state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [IW-1:0]    idx_q, idx_d, ptr_q, ptr_d, ptr_nxt, lo_win;
  logic [7:0]       hold_q, hold_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d, rearb, lo_found;
  int               c;
  // slot after the current low-priority owner, wrapping back to requester 1
  assign ptr_nxt = (idx_q == IW'(N_REQ - 1)) ? IW'(1) : idx_q + IW'(1);
  // decide whether to re-arbitrate this edge, then pick requester 0 or the round-robin winner
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    idx_d     = idx_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    rearb     = 1'b0;
    lo_found  = 1'b0;
    lo_win    = '0;
    c         = 0;
    case (state_q)
      IDLE:                rearb = 1'b1;
      HI_ACTIVE, PREEMPT:  rearb = done[0];
      LO_ACTIVE: begin
        if (done[idx_q]) begin
          rearb = 1'b1;
          ptr_d = ptr_nxt;
        end else if (PREEMPT_EN && req[0]) begin
          state_d = PREEMPT;
          grant_d = N_REQ'(1);
          idx_d   = '0;
          cnt_d   = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
        end else if (hold_q == 8'(HOLD_MAX - 1)) begin
          rearb     = 1'b1;
          ptr_d     = ptr_nxt;
          timeout_d = 1'b1;
        end else begin
          hold_d = hold_q + 8'd1;
        end
      end
    endcase
    for (int k = 0; k < N_REQ - 1; k++) begin
      c = int'(ptr_d) + k;
      c = (c >= N_REQ) ? c - (N_REQ - 1) : c;
      if (!lo_found && req[c]) begin
        lo_found = 1'b1;
        lo_win   = IW'(c);
      end
    end
    if (rearb) begin
      state_d = req[0] ? HI_ACTIVE : lo_found ? LO_ACTIVE : IDLE;
      grant_d = req[0] ? N_REQ'(1) : lo_found ? N_REQ'(1) << lo_win : '0;
      idx_d   = (!req[0] && lo_found) ? lo_win : '0;
      ptr_d   = (!req[0] && lo_found) ? lo_win : ptr_d;
      hold_d  = (!req[0] && lo_found) ? 8'd0 : hold_d;
    end
  end
  // registered state and outputs, cleared the moment reset goes low
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      idx_q     <= '0;
      ptr_q     <= IW'(1);
      hold_q    <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      idx_q     <= idx_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end
  assign grant         = grant_q;
  assign accmodule     = idx_q;
  assign mstate        = state_q;
  assign timeout       = timeout_q;
  assign nb_interrupts = cnt_q;
endmodule

// File: tb/tb_priority_arbiter.sv
// tb_priority_arbiter: two arbiters (preemption on with a 2-bit counter, preemption off) against an owner-based model
module tb_priority_arbiter;
  localparam int N = 3;
  localparam int H = 2;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] req_a = '0, done_a = '0, req_b = '0, done_b = '0;
  logic [2:0] grant_a, grant_b;
  logic [1:0] acc_a, acc_b, st_a, st_b;
  logic       to_a, to_b;
  logic [1:0] nb_a;
  logic [7:0] nb_b;
  int asserts = 0;
  int fails = 0;
  int own[2], held[2], start[2], ints[2];
  bit pre[2], tmo[2];
  int cmax[2] = '{3, 255};
  bit pe[2] = '{1'b1, 1'b0};

  priority_arbiter #(.N_REQ(3), .HOLD_MAX(2), .CNT_W(2), .PREEMPT_EN(1'b1)) u_a (
    .clk(clk), .reset(reset), .req(req_a), .done(done_a), .grant(grant_a),
    .accmodule(acc_a), .mstate(st_a), .timeout(to_a), .nb_interrupts(nb_a));
  priority_arbiter #(.N_REQ(3), .HOLD_MAX(2), .CNT_W(8), .PREEMPT_EN(1'b0)) u_b (
    .clk(clk), .reset(reset), .req(req_b), .done(done_b), .grant(grant_b),
    .accmodule(acc_b), .mstate(st_b), .timeout(to_b), .nb_interrupts(nb_b));

  always #5 clk = ~clk;

  task automatic check(string name, int act, int exp);
    asserts++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // first requesting low-priority index at or after s, wrapping within 1..N-1
  function automatic int pick(logic [2:0] r, int s);
    for (int k = 0; k < N - 1; k++) begin
      int c;
      c = (s - 1 + k) % (N - 1) + 1;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  // one clock of the arbitration rules, in terms of who owns the grant and why
  task automatic step(int m, logic [2:0] r, logic [2:0] d);
    bit need;
    int w;
    need = 1'b0;
    tmo[m] = 1'b0;
    if (own[m] < 0) need = 1'b1;
    else if (own[m] == 0) need = d[0];
    else if (d[own[m]]) begin need = 1'b1; start[m] = own[m] % (N - 1) + 1; end
    else if (pe[m] && r[0]) begin own[m] = 0; pre[m] = 1'b1; ints[m] = (ints[m] < cmax[m]) ? ints[m] + 1 : ints[m]; end
    else if (held[m] + 1 >= H) begin tmo[m] = 1'b1; need = 1'b1; start[m] = own[m] % (N - 1) + 1; end
    else held[m]++;
    if (need) begin
      pre[m] = 1'b0;
      w = r[0] ? 0 : pick(r, start[m]);
      own[m] = w;
      if (w > 0) begin start[m] = w; held[m] = 0; end
    end
  endtask

  function automatic int e_grant(int m);
    return own[m] < 0 ? 0 : 1 << own[m];
  endfunction
  function automatic int e_acc(int m);
    return own[m] < 0 ? 0 : own[m];
  endfunction
  function automatic int e_st(int m);
    return own[m] < 0 ? 0 : own[m] > 0 ? 2 : pre[m] ? 3 : 1;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int m = 0; m < 2; m++) begin
        own[m] = -1; pre[m] = 1'b0; held[m] = 0; start[m] = 1; ints[m] = 0; tmo[m] = 1'b0;
      end
    end else begin
      step(0, req_a, done_a);
      step(1, req_b, done_b);
    end
  end

  always @(negedge clk) begin
    check("a_grant", int'(grant_a), e_grant(0));
    check("a_acc", int'(acc_a), e_acc(0));
    check("a_state", int'(st_a), e_st(0));
    check("a_timeout", int'(to_a), int'(tmo[0]));
    check("a_nb", int'(nb_a), ints[0]);
    check("b_grant", int'(grant_b), e_grant(1));
    check("b_acc", int'(acc_b), e_acc(1));
    check("b_state", int'(st_b), e_st(1));
    check("b_timeout", int'(to_b), int'(tmo[1]));
    check("b_nb", int'(nb_b), ints[1]);
  end

  task automatic drive(int m, logic [2:0] r, logic [2:0] d);
    if (m == 0) begin req_a = r; done_a = d; end
    else begin req_b = r; done_b = d; end
    @(posedge clk);
    #2;
  endtask

  initial begin
    #1 reset = 1'b0;
    #2;
    check("rst_grant", int'(grant_a), 0);
    check("rst_state", int'(st_a), 0);
    check("rst_nb", int'(nb_a), 0);
    @(posedge clk);
    #2 reset = 1'b1;
    drive(0, 3'b110, 3'b000);
    check("rr_first_grant", int'(grant_a), 3'b010);
    check("rr_first_state", int'(st_a), 2);
    drive(0, 3'b100, 3'b010);
    check("rr_next_grant", int'(grant_a), 3'b100);
    check("rr_next_acc", int'(acc_a), 2);
    drive(0, 3'b010, 3'b100);
    check("back_to_1", int'(grant_a), 3'b010);
    drive(0, 3'b100, 3'b000);
    check("hold1_grant", int'(grant_a), 3'b010);
    check("hold1_to", int'(to_a), 0);
    drive(0, 3'b100, 3'b000);
    check("to_pulse", int'(to_a), 1);
    check("to_grant", int'(grant_a), 3'b100);
    check("to_nb", int'(nb_a), 0);
    drive(0, 3'b100, 3'b000);
    check("to_one_cycle", int'(to_a), 0);
    drive(0, 3'b001, 3'b000);
    check("pre_state", int'(st_a), 3);
    check("pre_grant", int'(grant_a), 3'b001);
    check("pre_nb", int'(nb_a), 1);
    check("pre_beats_to", int'(to_a), 0);
    drive(0, 3'b100, 3'b001);
    check("resume_grant", int'(grant_a), 3'b100);
    drive(0, 3'b001, 3'b100);
    check("done_hi_state", int'(st_a), 1);
    check("done_hi_nb", int'(nb_a), 1);
    drive(0, 3'b000, 3'b001);
    check("idle_state", int'(st_a), 0);
    drive(0, 3'b010, 3'b000);
    drive(0, 3'b000, 3'b000);
    check("drop_ignored", int'(grant_a), 3'b010);
    drive(0, 3'b010, 3'b101);
    check("foreign_done_to", int'(to_a), 1);
    check("foreign_done_grant", int'(grant_a), 3'b010);
    for (int i = 0; i < 4; i++) begin
      drive(0, 3'b001, 3'b000);
      drive(0, 3'b010, 3'b001);
    end
    check("sat_nb", int'(nb_a), 3);
    check("sat_grant", int'(grant_a), 3'b010);
    #1 reset = 1'b0;
    #1;
    check("async_grant", int'(grant_a), 0);
    check("async_state", int'(st_a), 0);
    check("async_nb", int'(nb_a), 0);
    check("async_to", int'(to_a), 0);
    check("async_acc", int'(acc_a), 0);
    reset = 1'b1;
    drive(0, 3'b010, 3'b000);
    check("post_rst_grant", int'(grant_a), 3'b010);
    check("post_rst_to", int'(to_a), 0);
    drive(0, 3'b000, 3'b000);
    drive(1, 3'b010, 3'b000);
    check("np_grant", int'(grant_b), 3'b010);
    drive(1, 3'b011, 3'b000);
    check("np_no_pre_grant", int'(grant_b), 3'b010);
    check("np_no_pre_state", int'(st_b), 2);
    drive(1, 3'b011, 3'b010);
    check("np_hi_grant", int'(grant_b), 3'b001);
    check("np_nb", int'(nb_b), 0);
    drive(1, 3'b000, 3'b001);
    drive(1, 3'b010, 3'b000);
    drive(1, 3'b011, 3'b000);
    drive(1, 3'b011, 3'b000);
    check("np_to_pulse", int'(to_b), 1);
    check("np_to_hi_wins", int'(grant_b), 3'b001);
    drive(1, 3'b000, 3'b001);
    @(posedge clk);
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end
endmodule
